// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encoding and the packed command word
// that the sequencer queues.
package alu_pkg;

   typedef enum logic [2:0] {
      OP_OR   = 3'b000,
      OP_NAND = 3'b001,
      OP_XOR  = 3'b010,
      OP_MUL  = 3'b011,
      OP_ADD  = 3'b100,
      OP_INC  = 3'b101,
      OP_SUB  = 3'b110,
      OP_SHR  = 3'b111
   } alu_op_e;

   typedef struct packed {
      logic [3:0] a;
      logic [3:0] b;
      logic [2:0] key;
   } alu_cmd_t;

endpackage

// File: rtl/alu_cmd_sequencer_alu.sv
// Combinational 4-bit ALU producing an 8-bit answer; logic ops are
// zero-extended, arithmetic wraps modulo 256.
module alu_cmd_sequencer_alu
   import alu_pkg::*;
(
   input  logic [3:0] a_i,
   input  logic [3:0] b_i,
   input  logic [2:0] key_i,
   output logic [7:0] answer_o
);

   logic [7:0] a8;
   logic [7:0] b8;

   assign a8 = {4'h0, a_i};
   assign b8 = {4'h0, b_i};

   always_comb begin
      answer_o = 8'h00;
      case (alu_op_e'(key_i))
         OP_OR:   answer_o = a8 | b8;
         OP_NAND: answer_o = {4'h0, ~(a_i & b_i)};
         OP_XOR:  answer_o = a8 ^ b8;
         OP_MUL:  answer_o = a8 * b8;
         OP_ADD:  answer_o = a8 + b8;
         OP_INC:  answer_o = a8 + 8'd1;
         OP_SUB:  answer_o = a8 - b8;
         OP_SHR:  answer_o = a8 >> 1;
         default: answer_o = 8'h00;
      endcase
   end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Command FIFO feeding a combinational ALU from its head entry; results
// leave through a one-entry registered output stage.
module alu_cmd_sequencer
   import alu_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [3:0]               in_a,
   input  logic [3:0]               in_b,
   input  logic [2:0]               in_key,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [7:0]               out_answer,
   output logic [2:0]               out_key,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0]   FULL_LEVEL = (AW+1)'(DEPTH);
   localparam logic [AW:0]   LVL_ONE    = (AW+1)'(1);
   localparam logic [AW-1:0] PTR_ONE    = AW'(1);

   typedef enum logic {S_EMPTY = 1'b0, S_FULL = 1'b1} out_state_e;

   alu_cmd_t      mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   level_q, level_d;
   logic          init_q;
   out_state_e    state_q;
   logic          out_valid_q;
   logic [7:0]    answer_q;
   logic [2:0]    key_q;

   alu_cmd_t      cmd_in;
   alu_cmd_t      head;
   logic [7:0]    alu_answer;
   logic          push, pop, stage_free;

   assign cmd_in     = '{a: in_a, b: in_b, key: in_key};
   assign head       = mem_q[rd_ptr_q];
   // init_q keeps in_ready low until the first edge after reset release
   assign in_ready   = init_q && (level_q < FULL_LEVEL);
   assign push       = in_valid && in_ready;
   assign stage_free = (state_q == S_EMPTY) || out_ready;
   assign pop        = (level_q != '0) && stage_free;

   assign out_valid  = out_valid_q;
   assign out_answer = answer_q;
   assign out_key    = key_q;
   assign level      = level_q;

   alu_cmd_sequencer_alu u_alu (
      .a_i      (head.a),
      .b_i      (head.b),
      .key_i    (head.key),
      .answer_o (alu_answer)
   );

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      if (push && !pop)      level_d = level_q + LVL_ONE;
      else if (pop && !push) level_d = level_q - LVL_ONE;
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= cmd_in;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         init_q   <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         init_q   <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_EMPTY;
         out_valid_q <= 1'b0;
         answer_q    <= 8'h00;
         key_q       <= 3'b000;
      end else begin
         case (state_q)
            S_EMPTY: begin
               if (pop) begin
                  state_q     <= S_FULL;
                  out_valid_q <= 1'b1;
                  answer_q    <= alu_answer;
                  key_q       <= head.key;
               end
            end
            S_FULL: begin
               if (pop) begin
                  answer_q <= alu_answer;
                  key_q    <= head.key;
               end else if (out_ready) begin
                  state_q     <= S_EMPTY;
                  out_valid_q <= 1'b0;
               end
            end
            default: begin
               state_q     <= S_EMPTY;
               out_valid_q <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Randomized and directed bench for alu_cmd_sequencer against a queue-based
// reference model of the command stream.
module tb_alu_cmd_sequencer;

   localparam int DEPTH = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [3:0] in_a = 4'h0;
   logic [3:0] in_b = 4'h0;
   logic [2:0] in_key = 3'b000;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic [7:0] out_answer;
   logic [2:0] out_key;
   logic [2:0] level;

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   alu_cmd_sequencer #(.DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_a       (in_a),
      .in_b       (in_b),
      .in_key     (in_key),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_answer (out_answer),
      .out_key    (out_key),
      .level      (level)
   );

   // Reference: queue of pending commands plus the single held result.
   logic [10:0] mq[$];
   bit          m_ov = 1'b0;
   bit          m_started = 1'b0;
   logic [7:0]  m_ans = 8'h00;
   logic [2:0]  m_key = 3'b000;

   function automatic logic [7:0] ref_alu(input logic [3:0] a, input logic [3:0] b,
                                          input logic [2:0] k);
      int ia, ib, r;
      ia = int'(a);
      ib = int'(b);
      case (k)
         3'd0:    r = ia | ib;
         3'd1:    r = 15 - (ia & ib);
         3'd2:    r = ia ^ ib;
         3'd3:    r = ia * ib;
         3'd4:    r = ia + ib;
         3'd5:    r = ia + 1;
         3'd6:    r = (ia - ib + 256) % 256;
         default: r = ia / 2;
      endcase
      return r[7:0];
   endfunction

   initial begin : model
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            mq.delete();
            m_ov = 1'b0;
            m_ans = 8'h00;
            m_key = 3'b000;
            m_started = 1'b0;
         end else begin
            bit acc, ld;
            logic [10:0] h;
            acc = in_valid && m_started && (mq.size() < DEPTH);
            ld  = (mq.size() > 0) && (!m_ov || out_ready);
            if (ld) begin
               h = mq.pop_front();
               m_ans = ref_alu(h[10:7], h[6:3], h[2:0]);
               m_key = h[2:0];
               m_ov = 1'b1;
            end else if (m_ov && out_ready) begin
               m_ov = 1'b0;
            end
            if (acc) mq.push_back({in_a, in_b, in_key});
            m_started = 1'b1;
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic test_reset();
      repeat (2) @(negedge clk);
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0b want=0", out_valid); end
      total++; if (level !== 3'd0) begin bad++; $display("FAIL reset_level got=%0d want=0", level); end
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%0b want=0", in_ready); end
      total++; if (out_answer !== 8'h00) begin bad++; $display("FAIL reset_answer got=%02h want=00", out_answer); end
      total++; if (out_key !== 3'b000) begin bad++; $display("FAIL reset_key got=%0d want=0", out_key); end
      rst_n = 1'b1;
      @(negedge clk);
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL release_in_ready got=%0b want=1", in_ready); end
      $display("test_reset done");
   endtask

   task automatic test_all_ops();
      logic [7:0] exp [8];
      exp = '{8'h0F, 8'h0D, 8'h0D, 8'h42, 8'h11, 8'h07, 8'hFB, 8'h03};
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_a = 4'd6;
      in_b = 4'd11;
      for (int k = 0; k < 8; k++) begin
         in_key = 3'(k);
         @(negedge clk);
         if (k == 0) begin
            total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL ops_latency got valid=%0b want=0", out_valid); end
         end else begin
            total++;
            if (out_valid !== 1'b1 || out_answer !== exp[k-1] || out_key !== 3'(k-1)) begin
               bad++;
               $display("FAIL ops_result%0d got v=%0b ans=%02h key=%0d want v=1 ans=%02h key=%0d",
                        k-1, out_valid, out_answer, out_key, exp[k-1], k-1);
            end
         end
      end
      in_valid = 1'b0;
      @(negedge clk);
      total++;
      if (out_valid !== 1'b1 || out_answer !== exp[7] || out_key !== 3'd7) begin
         bad++;
         $display("FAIL ops_result7 got v=%0b ans=%02h key=%0d want v=1 ans=03 key=7", out_valid, out_answer, out_key);
      end
      @(negedge clk);
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL ops_drain got valid=%0b want=0", out_valid); end
      out_ready = 1'b0;
      $display("test_all_ops done");
   endtask

   task automatic test_backpressure();
      logic [7:0] exp_q[$];
      logic [7:0] e;
      int n_acc, n_got;
      n_acc = 0;
      n_got = 0;
      out_ready = 1'b0;
      for (int g = 0; g < 20 && n_acc < 5; g++) begin
         in_valid = 1'b1;
         in_a = 4'($urandom); in_b = 4'($urandom); in_key = 3'($urandom);
         if (in_ready) begin exp_q.push_back(ref_alu(in_a, in_b, in_key)); n_acc++; end
         @(negedge clk);
      end
      in_valid = 1'b0;
      total++; if (level !== 3'd4) begin bad++; $display("FAIL bp_level got=%0d want=4", level); end
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready got=%0b want=0", in_ready); end
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_out_valid got=%0b want=1", out_valid); end
      out_ready = 1'b1;
      for (int c = 0; c < 20; c++) begin
         if (out_valid) begin
            n_got++;
            total++;
            if (exp_q.size() == 0) begin
               bad++; $display("FAIL bp_extra got ans=%02h want none", out_answer);
            end else begin
               e = exp_q.pop_front();
               if (out_answer !== e) begin bad++; $display("FAIL bp_order got=%02h want=%02h", out_answer, e); end
            end
         end
         @(negedge clk);
      end
      total++; if (n_got !== 5) begin bad++; $display("FAIL bp_count got=%0d want=5", n_got); end
      out_ready = 1'b0;
      $display("test_backpressure done");
   endtask

   task automatic test_full_push_pop();
      logic [7:0] exp_q[$];
      logic [7:0] e;
      int n_acc, n_got;
      n_acc = 0;
      n_got = 0;
      out_ready = 1'b0;
      for (int g = 0; g < 20 && n_acc < 5; g++) begin
         in_valid = 1'b1;
         in_a = 4'($urandom); in_b = 4'($urandom); in_key = 3'($urandom);
         if (in_ready) begin exp_q.push_back(ref_alu(in_a, in_b, in_key)); n_acc++; end
         @(negedge clk);
      end
      in_a = 4'($urandom); in_b = 4'($urandom); in_key = 3'($urandom);
      out_ready = 1'b1;
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL fpp_ready_full got=%0b want=0", in_ready); end
      total++;
      e = exp_q.pop_front();
      if (out_valid !== 1'b1 || out_answer !== e) begin
         bad++; $display("FAIL fpp_retire got v=%0b ans=%02h want v=1 ans=%02h", out_valid, out_answer, e);
      end
      @(negedge clk);
      total++; if (level !== 3'd3) begin bad++; $display("FAIL fpp_level_after_pop got=%0d want=3", level); end
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL fpp_ready_after_pop got=%0b want=1", in_ready); end
      exp_q.push_back(ref_alu(in_a, in_b, in_key));
      out_ready = 1'b0;
      @(negedge clk);
      in_valid = 1'b0;
      total++; if (level !== 3'd4) begin bad++; $display("FAIL fpp_level_after_push got=%0d want=4", level); end
      out_ready = 1'b1;
      for (int c = 0; c < 15; c++) begin
         if (out_valid) begin
            n_got++;
            total++;
            if (exp_q.size() == 0) begin
               bad++; $display("FAIL fpp_extra got ans=%02h want none", out_answer);
            end else begin
               e = exp_q.pop_front();
               if (out_answer !== e) begin bad++; $display("FAIL fpp_order got=%02h want=%02h", out_answer, e); end
            end
         end
         @(negedge clk);
      end
      total++; if (n_got !== 5) begin bad++; $display("FAIL fpp_count got=%0d want=5", n_got); end
      out_ready = 1'b0;
      $display("test_full_push_pop done");
   endtask

   task automatic test_stall();
      logic [7:0] ans0, e;
      logic [2:0] key0;
      out_ready = 1'b0;
      in_valid = 1'b1;
      in_a = 4'($urandom); in_b = 4'($urandom); in_key = 3'($urandom);
      e = ref_alu(in_a, in_b, in_key);
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      total++;
      if (out_valid !== 1'b1 || out_answer !== e || out_key !== in_key) begin
         bad++; $display("FAIL stall_load got v=%0b ans=%02h key=%0d want v=1 ans=%02h key=%0d",
                         out_valid, out_answer, out_key, e, in_key);
      end
      ans0 = e;
      key0 = in_key;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         total++;
         if (out_valid !== 1'b1 || out_answer !== ans0 || out_key !== key0) begin
            bad++; $display("FAIL stall_hold%0d got v=%0b ans=%02h key=%0d want v=1 ans=%02h key=%0d",
                            c, out_valid, out_answer, out_key, ans0, key0);
         end
      end
      out_ready = 1'b1;
      @(negedge clk);
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL stall_retire got valid=%0b want=0", out_valid); end
      out_ready = 1'b0;
      $display("test_stall done");
   endtask

   task automatic test_reset_mid();
      out_ready = 1'b0;
      in_valid = 1'b1;
      for (int c = 0; c < 3; c++) begin
         in_a = 4'($urandom); in_b = 4'($urandom); in_key = 3'($urandom);
         @(negedge clk);
      end
      in_valid = 1'b0;
      total++; if (level !== 3'd2 || out_valid !== 1'b1) begin
         bad++; $display("FAIL rmid_setup got level=%0d v=%0b want level=2 v=1", level, out_valid);
      end
      #2 rst_n = 1'b0;
      #1;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rmid_valid got=%0b want=0", out_valid); end
      total++; if (level !== 3'd0) begin bad++; $display("FAIL rmid_level got=%0d want=0", level); end
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rmid_ready got=%0b want=0", in_ready); end
      total++; if (out_answer !== 8'h00 || out_key !== 3'b000) begin
         bad++; $display("FAIL rmid_outputs got ans=%02h key=%0d want ans=00 key=0", out_answer, out_key);
      end
      @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         total++;
         if (out_valid !== 1'b0 || level !== 3'd0) begin
            bad++; $display("FAIL rmid_stale%0d got v=%0b level=%0d want v=0 level=0", c, out_valid, level);
         end
      end
      out_ready = 1'b0;
      $display("test_reset_mid done");
   endtask

   task automatic test_random_wrap();
      int sent, got;
      sent = 0;
      got = 0;
      for (int cyc = 0; cyc < 400 && got < 20; cyc++) begin
         total++;
         if (out_valid !== m_ov || level !== 3'(mq.size()) || in_ready !== (m_started && mq.size() < DEPTH)) begin
            bad++; $display("FAIL rnd_ctrl cyc=%0d got v=%0b level=%0d rdy=%0b want v=%0b level=%0d",
                            cyc, out_valid, level, in_ready, m_ov, mq.size());
         end
         if (m_ov) begin
            total++;
            if (out_answer !== m_ans || out_key !== m_key) begin
               bad++; $display("FAIL rnd_data cyc=%0d got ans=%02h key=%0d want ans=%02h key=%0d",
                               cyc, out_answer, out_key, m_ans, m_key);
            end
         end
         out_ready = 1'($urandom_range(0, 1));
         if (sent < 20) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_a = 4'($urandom); in_b = 4'($urandom); in_key = 3'($urandom);
         end else begin
            in_valid = 1'b0;
         end
         if (in_valid && in_ready) sent++;
         if (out_valid && out_ready) got++;
         @(negedge clk);
      end
      in_valid = 1'b0;
      out_ready = 1'b0;
      total++; if (got !== 20) begin bad++; $display("FAIL rnd_count got=%0d want=20", got); end
      $display("test_random_wrap done sent=%0d got=%0d", sent, got);
   endtask

   initial begin
      test_reset();
      test_all_ops();
      test_backpressure();
      test_full_push_pop();
      test_stall();
      test_reset_mid();
      test_random_wrap();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
